mem_arbiter: RTL and testbench

Two-port controller that shares the single-port instruction/data memory between the fetch requester (port 0) and the load/store requester (port 1). It accepts one access at a time, drives the memory's request, read/write, address and write-data inputs from registers, waits the memory's read latency, and returns read data with a one-cycle acknowledge. Round-robin arbitration resolves simultaneous requests so neither requester starves.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port (0) and a
// load/store port (1); one access in flight, registered memory controls, one-cycle ack.
module mem_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_ack,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_ack,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  mem_req,
   output logic                  mem_rd_wr_bar,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   localparam logic [3:0] LatInit = 4'(RD_LAT - 1);

   state_e                  state_q, state_d;
   logic                    gnt_q, gnt_d;
   logic                    last_gnt_q, last_gnt_d;
   logic [3:0]              lat_cnt_q, lat_cnt_d;
   logic                    mem_req_q, mem_req_d;
   logic                    mem_rd_wr_bar_q, mem_rd_wr_bar_d;
   logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0]   mem_data_in_q, mem_data_in_d;
   logic                    p0_ack_q, p0_ack_d;
   logic                    p1_ack_q, p1_ack_d;
   logic [DATA_WIDTH-1:0]   p0_rdata_q, p0_rdata_d;
   logic [DATA_WIDTH-1:0]   p1_rdata_q, p1_rdata_d;
   logic                    busy_q, busy_d;
   logic                    sel;
   logic                    sel_we;

   always_comb begin
      state_d         = state_q;
      gnt_d           = gnt_q;
      last_gnt_d      = last_gnt_q;
      lat_cnt_d       = lat_cnt_q;
      mem_req_d       = mem_req_q;
      mem_rd_wr_bar_d = mem_rd_wr_bar_q;
      mem_address_d   = mem_address_q;
      mem_data_in_d   = mem_data_in_q;
      p0_ack_d        = 1'b0;
      p1_ack_d        = 1'b0;
      p0_rdata_d      = p0_rdata_q;
      p1_rdata_d      = p1_rdata_q;
      sel             = 1'b0;
      sel_we          = 1'b0;

      case (state_q)
         StIdle: begin
            if (p0_req || p1_req) begin
               // On a tie the port that did not win last time goes first.
               sel             = (p0_req && p1_req) ? ~last_gnt_q : p1_req;
               sel_we          = sel ? p1_we : p0_we;
               gnt_d           = sel;
               last_gnt_d      = sel;
               mem_address_d   = sel ? p1_addr : p0_addr;
               mem_data_in_d   = sel ? p1_wdata : p0_wdata;
               mem_req_d       = 1'b1;
               mem_rd_wr_bar_d = ~sel_we;
               lat_cnt_d       = sel_we ? 4'd0 : LatInit;
               state_d         = StAccess;
            end
         end
         StAccess: begin
            if (!mem_rd_wr_bar_q || (lat_cnt_q == 4'd0)) begin
               state_d         = StDone;
               mem_req_d       = 1'b0;
               mem_rd_wr_bar_d = 1'b1;
               if (mem_rd_wr_bar_q) begin
                  if (gnt_q) p1_rdata_d = mem_data_out;
                  else       p0_rdata_d = mem_data_out;
               end
               if (gnt_q) p1_ack_d = 1'b1;
               else       p0_ack_d = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         gnt_q           <= 1'b0;
         last_gnt_q      <= 1'b1;
         lat_cnt_q       <= 4'd0;
         mem_req_q       <= 1'b0;
         mem_rd_wr_bar_q <= 1'b1;
         mem_address_q   <= '0;
         mem_data_in_q   <= '0;
         p0_ack_q        <= 1'b0;
         p1_ack_q        <= 1'b0;
         p0_rdata_q      <= '0;
         p1_rdata_q      <= '0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         gnt_q           <= gnt_d;
         last_gnt_q      <= last_gnt_d;
         lat_cnt_q       <= lat_cnt_d;
         mem_req_q       <= mem_req_d;
         mem_rd_wr_bar_q <= mem_rd_wr_bar_d;
         mem_address_q   <= mem_address_d;
         mem_data_in_q   <= mem_data_in_d;
         p0_ack_q        <= p0_ack_d;
         p1_ack_q        <= p1_ack_d;
         p0_rdata_q      <= p0_rdata_d;
         p1_rdata_q      <= p1_rdata_d;
         busy_q          <= busy_d;
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_rd_wr_bar = mem_rd_wr_bar_q;
   assign mem_address   = mem_address_q;
   assign mem_data_in   = mem_data_in_q;
   assign p0_ack        = p0_ack_q;
   assign p1_ack        = p1_ack_q;
   assign p0_rdata      = p0_rdata_q;
   assign p1_rdata      = p1_rdata_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RD_LAT=2 instance (a) and RD_LAT=1 instance (b) share
// stimulus; each has its own memory model, and use_b picks which outputs are checked.
module tb_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;

   logic          a_p0_ack, a_p1_ack, a_mem_req, a_rwb, a_busy;
   logic [DW-1:0] a_p0_rdata, a_p1_rdata, a_din, a_dout;
   logic [AW-1:0] a_addr;
   logic          b_p0_ack, b_p1_ack, b_mem_req, b_rwb, b_busy;
   logic [DW-1:0] b_p0_rdata, b_p1_rdata, b_din, b_dout;
   logic [AW-1:0] b_addr;

   logic [DW-1:0] mem_a [0:4095];
   logic [DW-1:0] mem_b [0:4095];

   logic          use_b;
   logic          s_p0_ack, s_p1_ack, s_mem_req, s_rwb, s_busy;
   logic [DW-1:0] s_p0_rdata, s_p1_rdata, s_din;
   logic [AW-1:0] s_addr;

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
      .mem_req(a_mem_req), .mem_rd_wr_bar(a_rwb), .mem_address(a_addr),
      .mem_data_in(a_din), .mem_data_out(a_dout), .busy(a_busy)
   );

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(1)) u_dut_b (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
      .mem_req(b_mem_req), .mem_rd_wr_bar(b_rwb), .mem_address(b_addr),
      .mem_data_in(b_din), .mem_data_out(b_dout), .busy(b_busy)
   );

   assign a_dout = (a_mem_req && a_rwb) ? mem_a[a_addr] : 'x;
   assign b_dout = (b_mem_req && b_rwb) ? mem_b[b_addr] : 'x;

   always @(posedge clk) begin
      if (a_mem_req && !a_rwb) mem_a[a_addr] <= a_din;
      if (b_mem_req && !b_rwb) mem_b[b_addr] <= b_din;
   end

   assign s_p0_ack   = use_b ? b_p0_ack   : a_p0_ack;
   assign s_p1_ack   = use_b ? b_p1_ack   : a_p1_ack;
   assign s_p0_rdata = use_b ? b_p0_rdata : a_p0_rdata;
   assign s_p1_rdata = use_b ? b_p1_rdata : a_p1_rdata;
   assign s_mem_req  = use_b ? b_mem_req  : a_mem_req;
   assign s_rwb      = use_b ? b_rwb      : a_rwb;
   assign s_busy     = use_b ? b_busy     : a_busy;
   assign s_addr     = use_b ? b_addr     : a_addr;
   assign s_din      = use_b ? b_din      : a_din;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      p0_req = 1'b0;
      p1_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One complete access on one port; latency counts edges from raising req to seeing ack.
   task automatic do_acc(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int exp_lat, input int exp_req_cyc,
                         input logic [DW-1:0] exp_rd, input string tag);
      int cyc = 0;
      int req_cyc = 0;
      int wr_cyc = 0;
      int other = 0;
      bit got = 0;
      if (port) begin
         p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
      end else begin
         p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
      end
      while (!got && cyc < 20) begin
         tick();
         cyc++;
         if (s_mem_req) req_cyc++;
         if (s_mem_req && !s_rwb) wr_cyc++;
         if (port ? s_p0_ack : s_p1_ack) other++;
         if (port ? s_p1_ack : s_p0_ack) got = 1;
      end
      check({tag, " ack seen"}, 32'(got), 32'd1);
      check({tag, " latency"}, cyc, exp_lat);
      check({tag, " mem_req cycles"}, req_cyc, exp_req_cyc);
      check({tag, " write cycles"}, wr_cyc, we ? 1 : 0);
      check({tag, " other ack"}, other, 0);
      if (!we) check({tag, " rdata"}, port ? s_p1_rdata : s_p0_rdata, exp_rd);
      if (port) p1_req = 1'b0;
      else      p0_req = 1'b0;
      tick();
      check({tag, " busy after"}, 32'(s_busy), 32'd0);
      check({tag, " ack one cycle"}, 32'(port ? s_p1_ack : s_p0_ack), 32'd0);
   endtask

   initial begin
      int n_ack;
      int order [4];
      bit raise0, raise1, started;
      int run;

      for (int i = 0; i < 4096; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      mem_a[12'h010] = 32'hDEADBEEF;
      mem_a[12'h100] = 32'hA0A0A0A0;
      mem_a[12'h200] = 32'hB1B1B1B1;
      mem_b[12'hFFF] = 32'hCAFEF00D;

      use_b    = 1'b0;
      p0_we    = 1'b0; p1_we    = 1'b0;
      p0_addr  = '0;   p1_addr  = '0;
      p0_wdata = '0;   p1_wdata = '0;
      do_reset();

      check("rst mem_req", 32'(s_mem_req), 32'd0);
      check("rst rd_wr_bar", 32'(s_rwb), 32'd1);
      check("rst address", 32'(s_addr), 32'd0);
      check("rst data_in", s_din, 32'd0);
      check("rst acks", {30'd0, s_p1_ack, s_p0_ack}, 32'd0);
      check("rst p0_rdata", s_p0_rdata, 32'd0);
      check("rst p1_rdata", s_p1_rdata, 32'd0);
      check("rst busy", 32'(s_busy), 32'd0);

      // Plain read, then write/read-back on port 1.
      do_acc(1'b0, 1'b0, 12'h010, 32'h0, 3, 2, 32'hDEADBEEF, "p0 rd 010");
      do_acc(1'b1, 1'b1, 12'h020, 32'h12345678, 2, 1, 32'h0, "p1 wr 020");
      check("mem 020 written", mem_a[12'h020], 32'h12345678);
      do_acc(1'b1, 1'b0, 12'h020, 32'h0, 3, 2, 32'h12345678, "p1 rd 020");

      // Both ports hold requests continuously: grants alternate, one IDLE between accesses.
      do_reset();
      p0_we = 1'b0; p0_addr = 12'h100;
      p1_we = 1'b0; p1_addr = 12'h200;
      p0_req = 1'b1; p1_req = 1'b1;
      n_ack = 0; raise0 = 0; raise1 = 0; started = 0; run = 0;
      for (int c = 0; c < 60 && n_ack < 4; c++) begin
         tick();
         if (raise0) begin p0_req = 1'b1; raise0 = 0; end
         if (raise1) begin p1_req = 1'b1; raise1 = 0; end
         if (s_busy) begin
            if (started && run > 0) check("tie idle gap", run, 1);
            started = 1;
            run = 0;
         end else if (started) begin
            run++;
         end
         if (s_p0_ack && n_ack < 4) begin
            order[n_ack] = 0; n_ack++;
            check("tie p0 rdata", s_p0_rdata, 32'hA0A0A0A0);
            p0_req = 1'b0; raise0 = 1;
         end
         if (s_p1_ack && n_ack < 4) begin
            order[n_ack] = 1; n_ack++;
            check("tie p1 rdata", s_p1_rdata, 32'hB1B1B1B1);
            p1_req = 1'b0; raise1 = 1;
         end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      check("tie ack count", n_ack, 4);
      for (int i = 0; i < n_ack; i++) check("tie grant order", order[i], i % 2);
      tick();
      tick();

      // p1 arrives while p0's read is in ACCESS and must wait for the next IDLE.
      p0_we = 1'b0; p0_addr = 12'h010; p0_req = 1'b1;
      tick();
      p1_we = 1'b0; p1_addr = 12'h200; p1_req = 1'b1;
      tick();
      tick();
      check("wait p0 ack", 32'(s_p0_ack), 32'd1);
      check("wait p1 no ack", 32'(s_p1_ack), 32'd0);
      check("wait p0 rdata", s_p0_rdata, 32'hDEADBEEF);
      p0_req = 1'b0;
      tick();
      check("wait idle gap", 32'(s_busy), 32'd0);
      tick();
      check("wait p1 granted", 32'(s_addr), 32'h200);
      check("wait p1 mem_req", 32'(s_mem_req), 32'd1);
      tick();
      tick();
      check("wait p1 ack", 32'(s_p1_ack), 32'd1);
      check("wait p1 rdata", s_p1_rdata, 32'hB1B1B1B1);
      check("wait p0 rdata kept", s_p0_rdata, 32'hDEADBEEF);
      p1_req = 1'b0;
      tick();

      // Reset during the second ACCESS cycle of a read drops it without an ack.
      p0_we = 1'b0; p0_addr = 12'h010; p0_req = 1'b1;
      tick();
      tick();
      check("abort in access", 32'(s_mem_req), 32'd1);
      rst = 1'b1;
      p0_req = 1'b0;
      tick();
      rst = 1'b0;
      check("abort mem_req", 32'(s_mem_req), 32'd0);
      check("abort p0 ack", 32'(s_p0_ack), 32'd0);
      check("abort p0 rdata", s_p0_rdata, 32'd0);
      check("abort p1 rdata", s_p1_rdata, 32'd0);
      tick();
      check("abort late ack", 32'(s_p0_ack), 32'd0);
      do_acc(1'b0, 1'b0, 12'h010, 32'h0, 3, 2, 32'hDEADBEEF, "p0 rd after abort");

      // Single-cycle read latency at the top of the address space.
      use_b = 1'b1;
      do_reset();
      do_acc(1'b0, 1'b0, 12'hFFF, 32'h0, 2, 1, 32'hCAFEF00D, "lat1 p0 rd fff");
      do_acc(1'b1, 1'b1, 12'hFFF, 32'h5A5AA5A5, 2, 1, 32'h0, "lat1 p1 wr fff");
      do_acc(1'b1, 1'b0, 12'hFFF, 32'h0, 2, 1, 32'h5A5AA5A5, "lat1 p1 rd fff");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
